// File: rtl/seq_detect_param.sv
// rtl/seq_detect_param.sv - parameterised serial pattern detector with Mealy match and saturating count
// Optional build macro: SEQDET_CNT_EN (match counter present when defined, tied to 0 otherwise).
module seq_detect_param #(
  parameter int                 PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1001,
  parameter bit                 OVERLAP = 1'b1,
  parameter int                 CNT_W   = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic                         x,
  input  logic                         clr,
  output logic                         y,
  output logic [CNT_W-1:0]             match_cnt,
  output logic [$clog2(PAT_LEN+1)-1:0] fill
);

  localparam int                FILL_W = $clog2(PAT_LEN + 1);
  localparam logic [FILL_W-1:0] FULL   = FILL_W'(PAT_LEN - 1);

  generate
    if ((PAT_LEN < 2) || (PAT_LEN > 32)) begin : g_bad_len
      $error("seq_detect_param: PAT_LEN must be in 2..32");
    end
  endgenerate

  logic [PAT_LEN-2:0] r_hist;
  logic [FILL_W-1:0]  r_fill;
  logic [PAT_LEN-1:0] w_window;
  logic               w_full;

  assign w_window = {r_hist, x};
  assign w_full   = (r_fill == FULL);
  assign y        = en & w_full & (w_window == PATTERN);
  assign fill     = r_fill;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hist <= '0;
      r_fill <= '0;
    end else if (clr) begin
      r_hist <= '0;
      r_fill <= '0;
    end else if (en) begin
      if (y && !OVERLAP) begin
        // Non-overlapping: a fresh full pattern is required after every hit.
        r_hist <= '0;
        r_fill <= '0;
      end else begin
        r_hist <= w_window[PAT_LEN-2:0];
        if (!w_full) r_fill <= r_fill + FILL_W'(1);
      end
    end
  end

`ifdef SEQDET_CNT_EN
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (y && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign match_cnt = r_cnt;
`else
  assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// tb/tb_seq_detect_param.sv - directed self-checking bench for seq_detect_param
module tb_seq_detect_param;

`ifdef SEQDET_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n, en, x, clr;

  logic       y0, y1, y2, y3;
  logic [7:0] cnt0, cnt1, cnt3;
  logic [1:0] cnt2;
  logic [2:0] fill0, fill1, fill2;
  logic [3:0] fill3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_detect_param u0 (
    .clk(clk), .rst_n(rst_n), .en(en), .x(x), .clr(clr),
    .y(y0), .match_cnt(cnt0), .fill(fill0)
  );

  seq_detect_param #(.OVERLAP(1'b0)) u1 (
    .clk(clk), .rst_n(rst_n), .en(en), .x(x), .clr(clr),
    .y(y1), .match_cnt(cnt1), .fill(fill1)
  );

  seq_detect_param #(.CNT_W(2)) u2 (
    .clk(clk), .rst_n(rst_n), .en(en), .x(x), .clr(clr),
    .y(y2), .match_cnt(cnt2), .fill(fill2)
  );

  seq_detect_param #(.PAT_LEN(8), .PATTERN(8'hA5), .OVERLAP(1'b1)) u3 (
    .clk(clk), .rst_n(rst_n), .en(en), .x(x), .clr(clr),
    .y(y3), .match_cnt(cnt3), .fill(fill3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic b, input logic e, input logic c);
    @(negedge clk);
    en  = e;
    x   = b;
    clr = c;
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    en    = 1'b0;
    x     = 1'b0;
    clr   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  logic [6:0]  s1, ey1_0, ey1_1;
  logic [3:0]  s3;
  logic [15:0] s5, ey5, s6, ey6;
  logic        gx;
  int          pulses;

  initial begin
    s1 = 7'b1001001;  ey1_0 = 7'b0001001;  ey1_1 = 7'b0001000;
    s3 = 4'b1001;
    s5 = 16'b1001001001001001;  ey5 = 16'b0001001001001001;
    s6 = 16'hA5A5;              ey6 = 16'b0000000100000001;

    do_reset();
    chk("reset_y0", {31'd0, y0}, 32'd0);
    chk("reset_fill0", {29'd0, fill0}, 32'd0);
    chk("reset_cnt0", {24'd0, cnt0}, 32'd0);

    // Test 1 and 2: overlapping (u0) and non-overlapping (u1) on the same stream
    for (int i = 6; i >= 0; i--) begin
      step(s1[i], 1'b1, 1'b0);
      chk($sformatf("t1_y_bit%0d", 7 - i), {31'd0, y0}, {31'd0, ey1_0[i]});
      chk($sformatf("t2_y_bit%0d", 7 - i), {31'd0, y1}, {31'd0, ey1_1[i]});
    end
    idle();
    chk("t1_cnt", {24'd0, cnt0}, CNT_ON ? 32'd2 : 32'd0);
    chk("t1_fill", {29'd0, fill0}, 32'd3);
    chk("t2_cnt", {24'd0, cnt1}, CNT_ON ? 32'd1 : 32'd0);
    chk("t2_fill", {29'd0, fill1}, 32'd3);
    chk("t2_en0_y", {31'd0, y1}, 32'd0);

    // Test 3: qualified sampling with toggling x during en=0 gaps
    do_reset();
    pulses = 0;
    gx = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step(s3[3-k], 1'b1, 1'b0);
      chk($sformatf("t3_y_q%0d", k + 1), {31'd0, y0}, (k == 3) ? 32'd1 : 32'd0);
      if (y0) pulses++;
      if (k < 3) begin
        for (int g = 0; g < 3; g++) begin
          step(gx, 1'b0, 1'b0);
          gx = ~gx;
          chk("t3_y_gap", {31'd0, y0}, 32'd0);
          if (y0) pulses++;
        end
      end
    end
    chk("t3_pulses", pulses, 32'd1);

    // Test 4: asynchronous reset mid-pattern discards partial history
    do_reset();
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    chk("t4_fill_pre", {29'd0, fill0}, 32'd2);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t4_fill_in_rst", {29'd0, fill0}, 32'd0);
    chk("t4_y_in_rst", {31'd0, y0}, 32'd0);
    #1 rst_n = 1'b1;
    step(1'b1, 1'b1, 1'b0);
    chk("t4_y_after", {31'd0, y0}, 32'd0);
    idle();
    chk("t4_fill_after", {29'd0, fill0}, 32'd1);
    chk("t4_hist_lsb", {31'd0, u0.r_hist[0]}, 32'd1);

    // Test 5: 2-bit counter saturation, then clr coincident with a match
    do_reset();
    for (int i = 15; i >= 0; i--) begin
      step(s5[i], 1'b1, 1'b0);
      chk($sformatf("t5_y_bit%0d", 16 - i), {31'd0, y2}, {31'd0, ey5[i]});
    end
    idle();
    chk("t5_cnt_sat", {30'd0, cnt2}, CNT_ON ? 32'd3 : 32'd0);
    idle();
    idle();
    chk("t5_cnt_held", {30'd0, cnt2}, CNT_ON ? 32'd3 : 32'd0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    chk("t5_clr_y", {31'd0, y2}, 32'd1);
    idle();
    chk("t5_clr_cnt", {30'd0, cnt2}, 32'd0);
    chk("t5_clr_fill", {29'd0, fill2}, 32'd0);

    // Test 6: 8-bit pattern A5, overlapping, stream A5A5
    do_reset();
    for (int i = 15; i >= 0; i--) begin
      step(s6[i], 1'b1, 1'b0);
      chk($sformatf("t6_y_bit%0d", 16 - i), {31'd0, y3}, {31'd0, ey6[i]});
    end
    idle();
    chk("t6_cnt", {24'd0, cnt3}, CNT_ON ? 32'd2 : 32'd0);
    chk("t6_fill", {28'd0, fill3}, 32'd7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
